// File: rtl/host_bus_sync_pkg.sv
// Shared types and address-byte layout for the host bus front end.
// Imported by the strobe synchroniser and the top-level decoder.
package host_bus_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } bus_state_e;

  localparam int OEA_BIT  = 7;
  localparam int AINC_BIT = 6;
  localparam int SEL_BIT  = 4;
  localparam int ADDR_MSB = 3;

  // The pin bank is 16 bytes deep; the address wraps rather than saturates.
  function automatic logic [ADDR_MSB:0] next_addr(input logic [ADDR_MSB:0] addr);
    return addr + 4'd1;
  endfunction

endpackage

// File: rtl/host_bus_sync_strobe_sync.sv
// Two-flop synchroniser, history flop and registered edge detector for one
// active-low host strobe. Flops reset high so an idle strobe looks idle.
module host_bus_sync_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic fall,
  output logic rise
);

  logic s1_r;
  logic s2_r;
  logic s3_r;
  logic v1_r;
  logic v2_r;
  logic arm_r;
  logic fall_r;
  logic rise_r;

  // Synchronise the strobe and flag edges; a fall is only honoured once a
  // genuinely sampled high level has been seen, so a strobe held low across
  // reset release must rise and fall again before it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r   <= 1'b1;
      s2_r   <= 1'b1;
      s3_r   <= 1'b1;
      v1_r   <= 1'b0;
      v2_r   <= 1'b0;
      arm_r  <= 1'b0;
      fall_r <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      s1_r   <= strobe;
      s2_r   <= s1_r;
      s3_r   <= s2_r;
      v1_r   <= 1'b1;
      v2_r   <= v1_r;
      arm_r  <= arm_r | (v2_r & s2_r);
      fall_r <= arm_r & s3_r & ~s2_r;
      rise_r <= ~s3_r & s2_r;
    end
  end

  assign fall = fall_r;
  assign rise = rise_r;

endmodule

// File: rtl/host_bus_sync.sv
// Host-side front end of the pin-access stage: synchronises nWR/nRD/nD_A in
// the IFCLK domain and turns host cycles into clean single-clock controls.
module host_bus_sync
  import host_bus_sync_pkg::*;
#(
  parameter int FPGA_ID = 0
) (
  input  logic       IFCLK,
  input  logic       nRST,
  input  logic       nWR,
  input  logic       nRD,
  input  logic       nD_A,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  output logic [3:0] ADDR,
  output logic       SEL,
  output logic       OEA,
  output logic [7:0] WDATA,
  output logic       WSTB,
  input  logic [7:0] RDATA,
  output logic       RSTB,
  output logic       COLL
);

  localparam logic MY_SEL = 1'(FPGA_ID);

  logic wr_fall_s;
  logic wr_rise_s;
  logic rd_fall_s;
  logic rd_rise_s;
  logic nda_s1_r;
  logic nda_s2_r;

  bus_state_e state_r, state_s;
  logic [3:0] addr_r, addr_s;
  logic       sel_r, sel_s;
  logic       oea_r, oea_s;
  logic       ainc_r, ainc_s;
  logic [7:0] wdata_r, wdata_s;
  logic       wstb_r, wstb_s;
  logic [7:0] dout_r, dout_s;
  logic       doe_r, doe_s;
  logic       rstb_r, rstb_s;
  logic       coll_r, coll_s;
  logic       awr_r, awr_s;
  logic [7:0] hold_r, hold_s;

  host_bus_sync_strobe_sync u_wr_sync (
    .clk    (IFCLK),
    .rst_n  (nRST),
    .strobe (nWR),
    .fall   (wr_fall_s),
    .rise   (wr_rise_s)
  );

  host_bus_sync_strobe_sync u_rd_sync (
    .clk    (IFCLK),
    .rst_n  (nRST),
    .strobe (nRD),
    .fall   (rd_fall_s),
    .rise   (rd_rise_s)
  );

  // nD_A is set up well before nWR falls, so a plain two-flop sync suffices.
  always_ff @(posedge IFCLK or negedge nRST) begin
    if (!nRST) begin
      nda_s1_r <= 1'b1;
      nda_s2_r <= 1'b1;
    end else begin
      nda_s1_r <= nD_A;
      nda_s2_r <= nda_s1_r;
    end
  end

  // Next-state and next-output decode for the IDLE/WR/RD transaction FSM.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    sel_s   = sel_r;
    oea_s   = oea_r;
    ainc_s  = ainc_r;
    wdata_s = wdata_r;
    wstb_s  = 1'b0;
    dout_s  = dout_r;
    doe_s   = doe_r;
    rstb_s  = 1'b0;
    coll_s  = coll_r;
    awr_s   = awr_r;
    hold_s  = hold_r;
    case (state_r)
      ST_IDLE: begin
        if (wr_fall_s) begin
          // A simultaneous read fall loses to the write and is only flagged.
          state_s = ST_WR;
          awr_s   = nda_s2_r;
          coll_s  = coll_r | rd_fall_s;
        end else if (rd_fall_s) begin
          state_s = ST_RD;
          dout_s  = RDATA;
          doe_s   = (sel_r == MY_SEL);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR: begin
        hold_s = D_IN;
        coll_s = coll_r | rd_fall_s;
        if (wr_rise_s) begin
          state_s = ST_IDLE;
          if (awr_r) begin
            oea_s  = hold_r[OEA_BIT];
            ainc_s = hold_r[AINC_BIT];
            sel_s  = hold_r[SEL_BIT];
            addr_s = hold_r[ADDR_MSB:0];
          end else if (sel_r == MY_SEL) begin
            wdata_s = hold_r;
            wstb_s  = 1'b1;
            addr_s  = ainc_r ? next_addr(addr_r) : addr_r;
          end else begin
            addr_s = addr_r;
          end
        end else begin
          state_s = ST_WR;
        end
      end
      ST_RD: begin
        coll_s = coll_r | wr_fall_s;
        if (rd_rise_s) begin
          state_s = ST_IDLE;
          doe_s   = 1'b0;
          rstb_s  = 1'b1;
          addr_s  = (ainc_r && (sel_r == MY_SEL)) ? next_addr(addr_r) : addr_r;
        end else begin
          state_s = ST_RD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        doe_s   = 1'b0;
      end
    endcase
  end

  // Transaction state and every host/pin-stage output are registered here.
  always_ff @(posedge IFCLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= ST_IDLE;
      addr_r  <= 4'd0;
      sel_r   <= 1'b0;
      oea_r   <= 1'b0;
      ainc_r  <= 1'b0;
      wdata_r <= 8'd0;
      wstb_r  <= 1'b0;
      dout_r  <= 8'd0;
      doe_r   <= 1'b0;
      rstb_r  <= 1'b0;
      coll_r  <= 1'b0;
      awr_r   <= 1'b0;
      hold_r  <= 8'd0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      sel_r   <= sel_s;
      oea_r   <= oea_s;
      ainc_r  <= ainc_s;
      wdata_r <= wdata_s;
      wstb_r  <= wstb_s;
      dout_r  <= dout_s;
      doe_r   <= doe_s;
      rstb_r  <= rstb_s;
      coll_r  <= coll_s;
      awr_r   <= awr_s;
      hold_r  <= hold_s;
    end
  end

  assign D_OUT = dout_r;
  assign D_OE  = doe_r;
  assign ADDR  = addr_r;
  assign SEL   = sel_r;
  assign OEA   = oea_r;
  assign WDATA = wdata_r;
  assign WSTB  = wstb_r;
  assign RSTB  = rstb_r;
  assign COLL  = coll_r;

endmodule

// File: tb/tb_host_bus_sync.sv
// Scoreboarded bench for host_bus_sync: expected write/read bytes are queued
// as host cycles are driven and popped when WSTB/RSTB appear.
module tb_host_bus_sync;

  logic       IFCLK = 1'b0;
  logic       nRST;
  logic       nWR;
  logic       nRD;
  logic       nD_A;
  logic [7:0] D_IN;
  logic [7:0] RDATA;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic [3:0] ADDR;
  logic       SEL;
  logic       OEA;
  logic [7:0] WDATA;
  logic       WSTB;
  logic       RSTB;
  logic       COLL;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] wr_q[$];
  logic [7:0] rd_q[$];

  logic [3:0] exp_addr;
  logic       exp_sel;
  logic       exp_oea;
  logic       exp_ainc;

  host_bus_sync #(.FPGA_ID(0)) dut (
    .IFCLK (IFCLK),
    .nRST  (nRST),
    .nWR   (nWR),
    .nRD   (nRD),
    .nD_A  (nD_A),
    .D_IN  (D_IN),
    .D_OUT (D_OUT),
    .D_OE  (D_OE),
    .ADDR  (ADDR),
    .SEL   (SEL),
    .OEA   (OEA),
    .WDATA (WDATA),
    .WSTB  (WSTB),
    .RDATA (RDATA),
    .RSTB  (RSTB),
    .COLL  (COLL)
  );

  always #5 IFCLK = ~IFCLK;

  // Scoreboard side: pop and compare whenever the DUT emits a strobe.
  always @(negedge IFCLK) begin
    logic [7:0] exp_b;
    if (nRST === 1'b1) begin
      if (WSTB === 1'b1 && RSTB === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL strobe_overlap: WSTB=%b RSTB=%b, required not both 1", WSTB, RSTB);
      end
      if (WSTB === 1'b1) begin
        vectors++;
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL wstb_unexpected: WSTB=1 WDATA=%h, required no write strobe", WDATA);
        end else begin
          exp_b = wr_q.pop_front();
          if (WDATA !== exp_b) begin
            miscompares++;
            $display("FAIL wdata: got %h, required %h", WDATA, exp_b);
          end
        end
      end
      if (RSTB === 1'b1) begin
        vectors++;
        if (rd_q.size() == 0) begin
          miscompares++;
          $display("FAIL rstb_unexpected: RSTB=1 D_OUT=%h, required no read strobe", D_OUT);
        end else begin
          exp_b = rd_q.pop_front();
          if (D_OUT !== exp_b) begin
            miscompares++;
            $display("FAIL read_dout: got %h, required %h", D_OUT, exp_b);
          end
        end
      end
    end
  end

  task automatic check_fields(input string tag);
    vectors++;
    if ({ADDR, SEL, OEA} !== {exp_addr, exp_sel, exp_oea}) begin
      miscompares++;
      $display("FAIL %s: ADDR=%0d SEL=%b OEA=%b, required ADDR=%0d SEL=%b OEA=%b",
               tag, ADDR, SEL, OEA, exp_addr, exp_sel, exp_oea);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; nWR = 1'b1; nRD = 1'b1; nD_A = 1'b1; D_IN = 8'h00; RDATA = 8'h00;
    repeat (3) @(posedge IFCLK);
    #1;
    vectors++;
    if ({D_OUT, D_OE, ADDR, SEL, OEA, WDATA, WSTB, RSTB, COLL} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0",
               {D_OUT, D_OE, ADDR, SEL, OEA, WDATA, WSTB, RSTB, COLL});
    end
    #1 nRST = 1'b1;
    exp_addr = 4'd0; exp_sel = 1'b0; exp_oea = 1'b0; exp_ainc = 1'b0;
    repeat (6) @(posedge IFCLK);
  endtask

  // One host write cycle; checks strobe presence and rise-to-WSTB latency.
  task automatic host_write(input logic nda, input logic [7:0] data, input string tag);
    logic expect_stb;
    logic seen;
    int   lat;
    expect_stb = (nda == 1'b0) && (exp_sel == 1'b0);
    @(posedge IFCLK);
    #2 nD_A = nda; D_IN = data;
    if (expect_stb) wr_q.push_back(data);
    repeat (2) @(posedge IFCLK);
    #2 nWR = 1'b0;
    repeat (6) @(posedge IFCLK);
    #2 nWR = 1'b1;
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge IFCLK);
      #1;
      if (WSTB === 1'b1 && !seen) begin
        seen = 1'b1; lat = i;
      end
    end
    vectors++;
    if (expect_stb && (!seen || lat < 3 || lat > 4)) begin
      miscompares++;
      $display("FAIL %s_wstb_latency: seen=%b latency=%0d, required seen=1 latency 3..4", tag, seen, lat);
    end else if (!expect_stb && seen) begin
      miscompares++;
      $display("FAIL %s_no_wstb: seen=%b, required 0", tag, seen);
    end
    if (nda) begin
      exp_oea = data[7]; exp_ainc = data[6]; exp_sel = data[4]; exp_addr = data[3:0];
    end else if (expect_stb && exp_ainc) begin
      exp_addr = exp_addr + 4'd1;
    end
    check_fields({tag, "_fields"});
  endtask

  // One host read cycle; RDATA is changed mid-read to prove D_OUT is frozen.
  task automatic host_read(input logic [7:0] rdata, input string tag);
    logic expect_oe;
    logic seen;
    int   lat;
    expect_oe = (exp_sel == 1'b0);
    @(posedge IFCLK);
    #2 RDATA = rdata;
    rd_q.push_back(rdata);
    repeat (2) @(posedge IFCLK);
    #2 nRD = 1'b0;
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge IFCLK);
      #1;
      if (D_OE === 1'b1 && !seen) begin
        seen = 1'b1; lat = i;
      end
    end
    vectors++;
    if (expect_oe && (!seen || lat < 3 || lat > 4)) begin
      miscompares++;
      $display("FAIL %s_doe_latency: seen=%b latency=%0d, required seen=1 latency 3..4", tag, seen, lat);
    end else if (!expect_oe && seen) begin
      miscompares++;
      $display("FAIL %s_doe_foreign: seen=%b, required 0", tag, seen);
    end
    RDATA = ~rdata;
    @(posedge IFCLK);
    #1;
    vectors++;
    if (D_OUT !== rdata || D_OE !== expect_oe) begin
      miscompares++;
      $display("FAIL %s_during: D_OUT=%h D_OE=%b, required D_OUT=%h D_OE=%b",
               tag, D_OUT, D_OE, rdata, expect_oe);
    end
    #1 nRD = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge IFCLK);
      #1;
      if (RSTB === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || D_OE !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_complete: rstb_seen=%b D_OE=%b, required 1 and 0", tag, seen, D_OE);
    end
    if (expect_oe && exp_ainc) exp_addr = exp_addr + 4'd1;
    check_fields({tag, "_fields"});
  endtask

  task automatic test_address_and_data();
    host_write(1'b1, 8'h45, "addr_write");
    host_write(1'b0, 8'hA5, "data_a5");
    host_write(1'b0, 8'h5A, "data_5a");
  endtask

  task automatic test_foreign_select();
    host_write(1'b1, 8'h10, "foreign_addr");
    host_write(1'b0, 8'h77, "foreign_data");
    host_write(1'b1, 8'h53, "foreign_ainc_addr");
    host_write(1'b0, 8'h66, "foreign_ainc_data");
    host_read(8'h81, "foreign_read");
  endtask

  task automatic test_read_wrap();
    host_write(1'b1, 8'h4F, "wrap_addr");
    host_read(8'h3C, "read_wrap");
  endtask

  task automatic test_collision();
    logic oe_seen;
    host_write(1'b1, 8'h42, "coll_addr");
    @(posedge IFCLK);
    #2 nD_A = 1'b0; D_IN = 8'h99;
    wr_q.push_back(8'h99);
    oe_seen = 1'b0;
    repeat (2) @(posedge IFCLK);
    #2 nWR = 1'b0;
    repeat (2) @(posedge IFCLK);
    #2 nRD = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge IFCLK);
      #1;
      if (D_OE === 1'b1) oe_seen = 1'b1;
    end
    #1 nWR = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge IFCLK);
      #1;
      if (D_OE === 1'b1) oe_seen = 1'b1;
    end
    #1 nRD = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge IFCLK);
      #1;
      if (D_OE === 1'b1) oe_seen = 1'b1;
    end
    exp_addr = exp_addr + 4'd1;
    vectors++;
    if (COLL !== 1'b1 || oe_seen) begin
      miscompares++;
      $display("FAIL collision: COLL=%b oe_seen=%b, required COLL=1 oe_seen=0", COLL, oe_seen);
    end
    vectors++;
    if (wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL collision_write: pending=%0d, required 0", wr_q.size());
    end
    check_fields("collision_fields");
  endtask

  task automatic test_reset_mid_read();
    logic seen;
    host_write(1'b1, 8'h47, "mid_addr");
    @(posedge IFCLK);
    #2 RDATA = 8'hE1;
    repeat (2) @(posedge IFCLK);
    #2 nRD = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge IFCLK);
      #1;
      if (D_OE === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL mid_read_start: D_OE seen=%b, required 1", seen);
    end
    #1 nRST = 1'b0;
    #1;
    vectors++;
    if ({D_OUT, D_OE, ADDR, SEL, OEA, WDATA, WSTB, RSTB, COLL} !== 26'd0) begin
      miscompares++;
      $display("FAIL mid_read_reset: got %h, required 0",
               {D_OUT, D_OE, ADDR, SEL, OEA, WDATA, WSTB, RSTB, COLL});
    end
    repeat (2) @(posedge IFCLK);
    #2 nRST = 1'b1;
    exp_addr = 4'd0; exp_sel = 1'b0; exp_oea = 1'b0; exp_ainc = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge IFCLK);
      #1;
      if (D_OE === 1'b1 || RSTB === 1'b1) seen = 1'b1;
    end
    #1 nRD = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge IFCLK);
      #1;
      if (D_OE === 1'b1 || RSTB === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL held_strobe_ignored: read activity=%b, required 0", seen);
    end
    host_read(8'h2D, "post_reset_read");
  endtask

  initial begin
    test_reset();
    test_address_and_data();
    test_foreign_select();
    test_read_wrap();
    test_collision();
    test_reset_mid_read();
    repeat (4) @(posedge IFCLK);
    vectors++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: wr pending=%0d rd pending=%0d, required 0 and 0",
               wr_q.size(), rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
